// File: rtl/mainfsm_if.sv
// Control interface between the multicycle ARM main FSM and its datapath.
// The controller is the master: it takes instruction fields and drives enables, selects and state.
interface mainfsm_if;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 4;

    logic [OP_W-1:0]    Op;
    logic [FUNCT_W-1:0] Funct;
    logic               IRWrite;
    logic               AdrSrc;
    logic [SEL_W-1:0]   ALUSrcA;
    logic [SEL_W-1:0]   ALUSrcB;
    logic [SEL_W-1:0]   ResultSrc;
    logic               NextPC;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               ALUOp;
    logic [STATE_W-1:0] state;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, state
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
               NextPC, RegW, MemW, Branch, ALUOp, state
    );
endinterface

// File: rtl/mainfsm.sv
// Moore main controller for the multicycle ARM datapath.
// Outputs are registered from the next-state decode, so they follow the state register exactly.
module mainfsm (
    input  logic      clk,
    input  logic      reset,
    mainfsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;

    // Only I (bit 5) and L/S (bit 0) steer sequencing; cmd/S bits belong to the ALU decoder.
    logic funct_unused;
    assign funct_unused = ^bus.Funct[4:1];

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            DECODE: begin
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            MEMADR: begin
                c.alu_src_b  = 2'b01;
            end
            MEMRD: begin
                c.adr_src    = 1'b1;
            end
            MEMWB: begin
                c.result_src = 2'b01;
                c.reg_w      = 1'b1;
            end
            MEMWR: begin
                c.adr_src    = 1'b1;
                c.mem_w      = 1'b1;
            end
            EXECUTER: begin
                c.alu_op     = 1'b1;
            end
            EXECUTEI: begin
                c.alu_src_b  = 2'b01;
                c.alu_op     = 1'b1;
            end
            ALUWB: begin
                c.reg_w      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.branch     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    // Next state plus the output decode that will be registered with it.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = bus.Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.IRWrite   = ctrl_q.ir_write;
    assign bus.AdrSrc    = ctrl_q.adr_src;
    assign bus.ALUSrcA   = ctrl_q.alu_src_a;
    assign bus.ALUSrcB   = ctrl_q.alu_src_b;
    assign bus.ResultSrc = ctrl_q.result_src;
    assign bus.NextPC    = ctrl_q.next_pc;
    assign bus.RegW      = ctrl_q.reg_w;
    assign bus.MemW      = ctrl_q.mem_w;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.ALUOp     = ctrl_q.alu_op;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: an instruction-level model (phase queue per instruction) checked every cycle,
// plus literal expectations for the directed instruction scenarios and asynchronous resets.
module tb_mainfsm;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mainfsm_if bus();
    mainfsm dut (.clk(clk), .reset(reset), .bus(bus));

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXR = 6, P_EXI = 7, P_ALUWB = 8, P_BRANCH = 9, P_UNK = 10;
    localparam logic [12:0] FETCH_OUT = 13'b1_0_01_10_10_1_0_0_0_0;

    int n_cmp = 0;
    int n_bad = 0;
    int cur;
    int rest[$];
    int cls;
    int len;
    int cpi[6] = '{0, 5, 4, 4, 3, 3};

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
    function automatic logic [12:0] exp_out(input int p);
        case (p)
            P_FETCH:  return 13'b1_0_01_10_10_1_0_0_0_0;
            P_DECODE: return 13'b0_0_01_10_10_0_0_0_0_0;
            P_MEMADR: return 13'b0_0_00_01_00_0_0_0_0_0;
            P_MEMRD:  return 13'b0_1_00_00_00_0_0_0_0_0;
            P_MEMWB:  return 13'b0_0_00_00_01_0_1_0_0_0;
            P_MEMWR:  return 13'b0_1_00_00_00_0_0_1_0_0;
            P_EXR:    return 13'b0_0_00_00_00_0_0_0_0_1;
            P_EXI:    return 13'b0_0_00_01_00_0_0_0_0_1;
            P_ALUWB:  return 13'b0_0_00_00_00_0_1_0_0_0;
            P_BRANCH: return 13'b0_0_10_01_10_0_0_0_1_0;
            default:  return 13'b0;
        endcase
    endfunction

    function automatic logic [12:0] act_out();
        return {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        cur = P_FETCH;
        rest.delete();
        cls = 0;
        len = 0;
    endtask

    // Advance the instruction model by one edge, classifying when the fields are sampled.
    task automatic model_edge();
        len++;
        if (cur == P_FETCH) begin
            cur = P_DECODE;
        end else if (cur == P_DECODE) begin
            case (bus.Op)
                2'b00: begin cur = bus.Funct[5] ? P_EXI : P_EXR; rest.push_back(P_ALUWB); cls = 3; end
                2'b01: cur = P_MEMADR;
                2'b10: begin cur = P_BRANCH; cls = 4; end
                default: begin cur = P_UNK; cls = 5; end
            endcase
        end else if (cur == P_MEMADR) begin
            if (bus.Funct[0]) begin cur = P_MEMRD; rest.push_back(P_MEMWB); cls = 1; end
            else begin cur = P_MEMWR; cls = 2; end
        end else if (rest.size() != 0) begin
            cur = rest.pop_front();
        end else begin
            check("cycles_per_instr", 13'(len), 13'(cpi[cls]));
            cur = P_FETCH;
            len = 0;
            cls = 0;
        end
    endtask

    task automatic compare_now();
        check("outputs", act_out(), exp_out(cur));
        check("single_write_enable", 13'($countones({bus.RegW, bus.MemW, bus.IRWrite}) <= 1), 13'd1);
    endtask

    task automatic tick(input logic [1:0] op, input logic [5:0] f);
        bus.Op = op;
        bus.Funct = f;
        @(posedge clk);
        model_edge();
        #1;
        compare_now();
    endtask

    task automatic tick_rand();
        tick(2'($urandom_range(0, 3)), 6'($urandom));
    endtask

    // Mid-cycle asynchronous reset: outputs must snap to the FETCH decode before the next edge.
    task automatic async_reset(input string name);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check({name, "_out"}, act_out(), FETCH_OUT);
        check({name, "_regw"}, 13'(bus.RegW), 13'd0);
        check({name, "_memw"}, 13'(bus.MemW), 13'd0);
        check({name, "_irwrite"}, 13'(bus.IRWrite), 13'd1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.Op = 2'b00;
        bus.Funct = 6'b0;
        model_reset();
        #2;
        check("reset_out", act_out(), FETCH_OUT);
        @(negedge clk);
        reset = 1'b0;

        // LDR with field toggling while in MEMRD
        tick(2'b01, 6'b011001);
        check("ldr_decode", act_out(), 13'b0_0_01_10_10_0_0_0_0_0);
        tick(2'b01, 6'b011001);
        tick(2'b01, 6'b011001);
        check("ldr_memrd_adrsrc", 13'(bus.AdrSrc), 13'd1);
        tick_rand();
        check("ldr_memwb_regw", 13'(bus.RegW), 13'd1);
        check("ldr_memwb_resultsrc", 13'(bus.ResultSrc), 13'd1);
        tick_rand();
        check("ldr_back_to_fetch", act_out(), FETCH_OUT);

        // STR
        tick(2'b01, 6'b011000);
        tick(2'b01, 6'b011000);
        tick(2'b01, 6'b011000);
        check("str_memw", 13'({bus.MemW, bus.AdrSrc, bus.RegW}), 13'b110);
        tick_rand();
        check("str_memw_drops", 13'(bus.MemW), 13'd0);

        // ADD register, toggling during EXECUTER, then reset in ALUWB
        tick(2'b00, 6'b001000);
        tick(2'b00, 6'b001000);
        check("addr_exec", 13'({bus.ALUSrcB, bus.ALUOp}), 13'b001);
        tick_rand();
        check("addr_aluwb", 13'({bus.RegW, bus.ResultSrc}), 13'b100);
        async_reset("reset_in_aluwb");

        // ADD immediate
        tick(2'b00, 6'b101000);
        tick(2'b00, 6'b101000);
        check("addi_exec", 13'({bus.ALUSrcB, bus.ALUOp}), 13'b011);
        tick_rand();
        check("addi_aluwb", 13'({bus.RegW, bus.ResultSrc}), 13'b100);
        tick_rand();

        // Branch
        tick(2'b10, 6'b000000);
        tick(2'b10, 6'b000000);
        check("b_branch", 13'({bus.Branch, bus.ALUSrcA, bus.ALUSrcB}), 13'b11001);
        tick_rand();

        // Undefined opcode
        tick(2'b11, 6'b111111);
        tick(2'b11, 6'b111111);
        check("unknown_all_zero", act_out(), 13'b0);
        tick_rand();
        check("unknown_to_fetch", act_out(), FETCH_OUT);

        // STR aborted by reset while in MEMWR
        tick(2'b01, 6'b000000);
        tick(2'b01, 6'b000000);
        tick(2'b01, 6'b000000);
        async_reset("reset_in_memwr");

        // Random instruction stream with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
            else tick_rand();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
